// File: rtl/fifo_vr_pkt.sv
// fifo_vr_pkt: data/last FIFO with valid-ready on both sides, any DEPTH >= 2.
//   Optional store-and-forward (PKT_MODE=1): the read side only presents data
//   once at least one complete packet (a row with last=1) is stored, or when the
//   FIFO is full (so packets longer than DEPTH still drain, cut-through style).
// Ports:
//   clk, sync_rst (sync, active-high), en (low = stall, state held)
//   data_in / data_in_last / data_in_valid / data_in_ready      write side
//   data_out / data_out_last / data_out_valid / data_out_ready  read side
//   status_count, status_pkt_count, status_almost_full, status_full, status_empty
//
// Handshake: a transfer happens on a posedge where valid & ready are both high.
//   ready and valid are each decoded from registered state and en only; neither
//   looks at the other side's valid/ready, so no combinational loop can form.
//   A full FIFO refuses a write even if a read happens in the same cycle.
module fifo_vr_pkt #(
  parameter int DEPTH        = 4,
  parameter int DATA_W       = 32,
  parameter bit PKT_MODE     = 1'b0,
  parameter int AFULL_THRESH = DEPTH - 1,
  parameter int CNT_W        = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              sync_rst,
  input  logic              en,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_in_last,
  input  logic              data_in_valid,
  output logic              data_in_ready,
  output logic [DATA_W-1:0] data_out,
  output logic              data_out_last,
  output logic              data_out_valid,
  input  logic              data_out_ready,
  output logic [CNT_W-1:0]  status_count,
  output logic [CNT_W-1:0]  status_pkt_count,
  output logic              status_almost_full,
  output logic              status_full,
  output logic              status_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AFULL_C  = CNT_W'(AFULL_THRESH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [DATA_W-1:0] mem_data [DEPTH];
  logic              mem_last [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] pkt_count;

  logic wr;
  logic rd;
  logic wr_last;
  logic rd_last;
  logic is_full;
  logic pkt_avail;

  // Explicit wrap so non-power-of-2 depths never index past the last row.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  assign is_full   = (count == DEPTH_C);
  // Full fallback keeps a packet longer than DEPTH from deadlocking in store-and-forward.
  assign pkt_avail = PKT_MODE ? ((pkt_count != '0) | is_full) : (count != '0);

  assign data_in_ready  = en & (count < DEPTH_C);
  assign data_out_valid = en & pkt_avail;

  assign wr      = data_in_valid & data_in_ready;
  assign rd      = data_out_valid & data_out_ready;
  assign wr_last = wr & data_in_last;
  assign rd_last = rd & data_out_last;

  // Fall-through read port: the row at rd_ptr is always presented.
  assign data_out      = mem_data[rd_ptr];
  assign data_out_last = mem_last[rd_ptr];

  assign status_count       = count;
  assign status_pkt_count   = pkt_count;
  assign status_almost_full = (count >= AFULL_C);
  assign status_full        = is_full;
  assign status_empty       = (count == '0);

  // Storage is never cleared; pointers and counters define what is valid.
  always_ff @(posedge clk) begin
    if (wr && !sync_rst) begin
      mem_data[wr_ptr] <= data_in;
      mem_last[wr_ptr] <= data_in_last;
    end
  end

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      pkt_count <= '0;
    end else begin
      if (wr) wr_ptr <= ptr_inc(wr_ptr);
      if (rd) rd_ptr <= ptr_inc(rd_ptr);

      case ({wr, rd})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase

      case ({wr_last, rd_last})
        2'b10:   pkt_count <= pkt_count + CNT_W'(1);
        2'b01:   pkt_count <= pkt_count - CNT_W'(1);
        default: pkt_count <= pkt_count;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_vr_pkt.sv
// tb_fifo_vr_pkt: four FIFO instances (D4 cut-through, D5 cut-through,
// D8 store-and-forward, D4 store-and-forward) sharing one clock. A reference
// queue holding {last,data} rows predicts every output each cycle.
module tb_fifo_vr_pkt;

  localparam int N = 4;

  logic       clk;
  logic       en   [N];
  logic       rst  [N];
  logic       vin  [N];
  logic       lin  [N];
  logic [7:0] din  [N];
  logic       ordy [N];
  logic       rdy  [N];
  logic       vld  [N];
  logic [7:0] dout [N];
  logic       dlast[N];
  logic [3:0] cnt  [N];
  logic [3:0] pcnt [N];
  logic       af   [N];
  logic       full [N];
  logic       empty[N];

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: rows in arrival order, bit 8 = last.
  logic [8:0] exp_q[$];
  bit         rd_fire, wr_fire, rd_last_seen;
  logic [7:0] rd_data;

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- DUTs ----------------
  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int D  = (g == 0) ? 4 : (g == 1) ? 5 : (g == 2) ? 8 : 4;
    localparam bit M  = (g >= 2);
    localparam int CW = $clog2(D + 1);
    logic [CW-1:0] c, pc;

    fifo_vr_pkt #(.DEPTH(D), .DATA_W(8), .PKT_MODE(M)) u_dut (
      .clk                (clk),
      .sync_rst           (rst[g]),
      .en                 (en[g]),
      .data_in            (din[g]),
      .data_in_last       (lin[g]),
      .data_in_valid      (vin[g]),
      .data_in_ready      (rdy[g]),
      .data_out           (dout[g]),
      .data_out_last      (dlast[g]),
      .data_out_valid     (vld[g]),
      .data_out_ready     (ordy[g]),
      .status_count       (c),
      .status_pkt_count   (pc),
      .status_almost_full (af[g]),
      .status_full        (full[g]),
      .status_empty       (empty[g])
    );
    assign cnt[g]  = 4'(c);
    assign pcnt[g] = 4'(pc);

    always @(negedge clk) begin
      if (!$isunknown(c))
        assert (int'(c) <= D) else $error("FAIL count_bound inst %0d: count %0d above depth %0d", g, c, D);
    end
  end

  function automatic int dep_of(input int i);
    case (i)
      1:       return 5;
      2:       return 8;
      default: return 4;
    endcase
  endfunction

  function automatic bit mode_of(input int i);
    return (i >= 2);
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- driver + model step ----------------
  task automatic cyc(input int i, input bit e, input bit r, input bit v, input bit l,
                     input logic [7:0] d, input bit o, input bit chk);
    int n, p, dd;
    bit er, ev;
    @(negedge clk);
    en[i] = e; rst[i] = r; vin[i] = v; lin[i] = l; din[i] = d; ordy[i] = o;
    #1;
    dd = dep_of(i);
    n  = exp_q.size();
    p  = 0;
    foreach (exp_q[j]) if (exp_q[j][8]) p++;
    er = e && (n < dd);
    ev = e && (mode_of(i) ? (p > 0 || n == dd) : (n > 0));
    if (chk) begin
      check($sformatf("i%0d_ready", i), 32'(rdy[i]), 32'(er));
      check($sformatf("i%0d_valid", i), 32'(vld[i]), 32'(ev));
      check($sformatf("i%0d_count", i), 32'(cnt[i]), 32'(n));
      check($sformatf("i%0d_pkt_count", i), 32'(pcnt[i]), 32'(p));
      check($sformatf("i%0d_full", i), 32'(full[i]), 32'(n == dd));
      check($sformatf("i%0d_empty", i), 32'(empty[i]), 32'(n == 0));
      check($sformatf("i%0d_afull", i), 32'(af[i]), 32'(n >= dd - 1));
      if (ev) begin
        check($sformatf("i%0d_data", i), 32'(dout[i]), 32'(exp_q[0][7:0]));
        check($sformatf("i%0d_last", i), 32'(dlast[i]), 32'(exp_q[0][8]));
      end
    end
    @(posedge clk);
    rd_fire = 1'b0;
    wr_fire = 1'b0;
    if (r) begin
      exp_q.delete();
    end else begin
      if (ev && o) begin
        rd_fire      = 1'b1;
        rd_data      = exp_q[0][7:0];
        rd_last_seen = exp_q[0][8];
        void'(exp_q.pop_front());
      end
      if (er && v) begin
        wr_fire = 1'b1;
        exp_q.push_back({l, d});
      end
    end
  endtask

  task automatic park(input int i);
    @(negedge clk);
    en[i] = 1'b0; rst[i] = 1'b0; vin[i] = 1'b0; ordy[i] = 1'b0;
  endtask

  // ---------------- directed vector table (instance 0: D4, cut-through) ----------------
  typedef struct {
    bit         e;
    bit         v;
    logic [7:0] d;
    bit         o;
    bit         x_rdy;
    bit         x_vld;
    int         x_cnt;
    bit         x_dchk;
    logic [7:0] x_d;
  } vec_t;

  vec_t tbl[14];

  initial begin
    int k, nr;
    bit v, o;

    for (int i = 0; i < N; i++) begin
      en[i] = 0; rst[i] = 1; vin[i] = 0; lin[i] = 0; din[i] = '0; ordy[i] = 0;
    end

    //             e  v  d      o  rdy vld cnt dchk d
    tbl[0]  = '{1, 1, 8'hA0, 0, 1, 0, 0, 0, 8'h00};
    tbl[1]  = '{1, 1, 8'hA1, 0, 1, 1, 1, 1, 8'hA0};
    tbl[2]  = '{1, 1, 8'hA2, 0, 1, 1, 2, 1, 8'hA0};
    tbl[3]  = '{1, 1, 8'hA3, 0, 1, 1, 3, 1, 8'hA0};
    tbl[4]  = '{1, 1, 8'hA4, 0, 0, 1, 4, 1, 8'hA0};
    tbl[5]  = '{1, 1, 8'hB0, 1, 0, 1, 4, 1, 8'hA0};
    tbl[6]  = '{1, 1, 8'hB0, 0, 1, 1, 3, 1, 8'hA1};
    tbl[7]  = '{1, 0, 8'h00, 1, 0, 1, 4, 1, 8'hA1};
    tbl[8]  = '{1, 1, 8'hB1, 1, 1, 1, 3, 1, 8'hA2};
    tbl[9]  = '{1, 0, 8'h00, 1, 1, 1, 3, 1, 8'hA3};
    tbl[10] = '{1, 0, 8'h00, 1, 1, 1, 2, 1, 8'hB0};
    tbl[11] = '{1, 0, 8'h00, 1, 1, 1, 1, 1, 8'hB1};
    tbl[12] = '{1, 0, 8'h00, 1, 1, 0, 0, 0, 8'h00};
    tbl[13] = '{0, 1, 8'hC0, 1, 0, 0, 0, 0, 8'h00};

    repeat (2) @(posedge clk);

    // Reset state of every instance, stalled and enabled.
    for (int i = 0; i < N; i++) begin
      exp_q.delete();
      cyc(i, 0, 0, 0, 0, 8'h00, 0, 1);
      cyc(i, 1, 0, 0, 0, 8'h00, 0, 1);
      park(i);
    end

    // Fill to full, refused write, read-while-full, simultaneous read/write.
    for (int t = 0; t < 14; t++) begin
      @(negedge clk);
      en[0] = tbl[t].e; vin[0] = tbl[t].v; lin[0] = 1'b0; din[0] = tbl[t].d; ordy[0] = tbl[t].o;
      #1;
      check($sformatf("tbl%0d_ready", t), 32'(rdy[0]), 32'(tbl[t].x_rdy));
      check($sformatf("tbl%0d_valid", t), 32'(vld[0]), 32'(tbl[t].x_vld));
      check($sformatf("tbl%0d_count", t), 32'(cnt[0]), 32'(tbl[t].x_cnt));
      check($sformatf("tbl%0d_full", t), 32'(full[0]), 32'(tbl[t].x_cnt == 4));
      check($sformatf("tbl%0d_empty", t), 32'(empty[0]), 32'(tbl[t].x_cnt == 0));
      check($sformatf("tbl%0d_afull", t), 32'(af[0]), 32'(tbl[t].x_cnt >= 3));
      if (tbl[t].x_dchk) check($sformatf("tbl%0d_data", t), 32'(dout[0]), 32'(tbl[t].x_d));
      @(posedge clk);
    end
    park(0);

    // DEPTH=5: 12 rows through with random valid/ready; order must be 0..11.
    exp_q.delete();
    k = 0; nr = 0;
    for (int t = 0; t < 400 && nr < 12; t++) begin
      v = (k < 12) && ($urandom_range(0, 1) == 1);
      o = ($urandom_range(0, 1) == 1);
      cyc(1, 1, 0, v, 0, 8'(k), o, 1);
      if (wr_fire) k++;
      if (rd_fire) begin
        check("t2_order", 32'(rd_data), 32'(nr));
        nr++;
      end
    end
    check("t2_all_read", 32'(nr), 32'd12);
    park(1);

    // DEPTH=8 store-and-forward: valid only once the last row is stored.
    exp_q.delete();
    cyc(2, 1, 0, 1, 0, 8'h11, 0, 1);
    cyc(2, 1, 0, 1, 0, 8'h12, 0, 1);
    #2;
    check("t4_valid_partial", 32'(vld[2]), 32'd0);
    check("t4_count_partial", 32'(cnt[2]), 32'd2);
    cyc(2, 1, 0, 1, 1, 8'h13, 0, 1);
    #2;
    check("t4_valid_pkt", 32'(vld[2]), 32'd1);
    check("t4_pkt_count", 32'(pcnt[2]), 32'd1);
    for (int t = 0; t < 3; t++) cyc(2, 1, 0, 0, 0, 8'h00, 1, 1);
    check("t4_last_on_third", 32'(rd_last_seen), 32'd1);
    cyc(2, 1, 0, 0, 0, 8'h00, 1, 1);
    park(2);

    // DEPTH=4 store-and-forward, 6-row packet: drains via the full fallback.
    exp_q.delete();
    k = 0; nr = 0;
    for (int t = 0; t < 60 && nr < 6; t++) begin
      cyc(3, 1, 0, (k < 6), (k == 5), 8'(8'h50 + k), 1, 1);
      if (wr_fire) k++;
      if (rd_fire) begin
        check("t5_order", 32'(rd_data), 32'(8'h50 + nr));
        check("t5_last", 32'(rd_last_seen), 32'(nr == 5));
        nr++;
      end
    end
    check("t5_all_read", 32'(nr), 32'd6);
    park(3);

    // Randomised traffic on every instance, with stalls and rare resets.
    for (int i = 0; i < N; i++) begin
      cyc(i, 1, 1, 0, 0, 8'h00, 0, 0);
      for (int t = 0; t < 300; t++) begin
        cyc(i, ($urandom_range(0, 9) != 0), ($urandom_range(0, 99) == 0),
            ($urandom_range(0, 2) != 0), ($urandom_range(0, 3) == 0),
            8'($urandom_range(0, 255)), ($urandom_range(0, 2) != 0), 1);
      end
      park(i);
    end

    // Mid-packet reset after a two-cycle stall.
    cyc(3, 1, 1, 0, 0, 8'h00, 0, 1);
    for (int t = 0; t < 3; t++) cyc(3, 1, 0, 1, 0, 8'(8'h70 + t), 0, 1);
    cyc(3, 0, 0, 1, 0, 8'h73, 1, 1);
    cyc(3, 0, 0, 1, 0, 8'h74, 1, 1);
    #2;
    check("t6_frozen_count", 32'(cnt[3]), 32'd3);
    cyc(3, 1, 1, 1, 1, 8'h75, 1, 1);
    #2;
    check("t6_count", 32'(cnt[3]), 32'd0);
    check("t6_pkt_count", 32'(pcnt[3]), 32'd0);
    check("t6_valid", 32'(vld[3]), 32'd0);
    check("t6_empty", 32'(empty[3]), 32'd1);
    cyc(3, 1, 0, 0, 0, 8'h00, 1, 1);
    park(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
